// File: rtl/adc_spi_responder.sv
// SPI slave that models an ADC conversion port: serialises {stale, channel, sample}
// on sdo1 while collecting a 16-bit command word from sdi1 in the same frame.
//
// state   | meaning
// IDLE    | waiting for sync1 low; sdo1 held at 0
// SHIFT   | frame in progress, one bit out and one bit in per edge
// WAIT_HI | 16 bits done; waiting for sync1 high before the next frame
module adc_spi_responder #(
    parameter logic [2:0]  RESET_CH     = 3'd0,
    parameter logic [11:0] RESET_SAMPLE = 12'h000
) (
    input  logic        sclk,
    input  logic        rst_n,
    input  logic        sync1,
    input  logic        sdi1,
    output logic        sdo1,
    input  logic [11:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic [2:0]  channel,
    output logic [15:0] cmd_word,
    output logic        frame_done,
    output logic        frame_abort
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SHIFT   = 2'd1;
    localparam logic [1:0] WAIT_HI = 2'd2;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [14:0] tx_sr;
    logic [14:0] rx_sr;
    logic        hold_full;
    logic [11:0] hold_data;
    logic [11:0] last_sample;

    logic        accept;
    logic        frame_start;
    logic [15:0] frame_word;
    logic [15:0] rx_word;

    assign sample_ready = ~hold_full;
    assign accept       = sample_valid & ~hold_full;
    assign frame_start  = (state == IDLE) & ~sync1;
    // An empty holding register means the master gets the previous sample again, flagged stale.
    assign frame_word   = {~hold_full, channel, (hold_full ? hold_data : last_sample)};
    assign rx_word      = {rx_sr, sdi1};

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 5'd0;
            tx_sr       <= 15'd0;
            rx_sr       <= 15'd0;
            sdo1        <= 1'b0;
            hold_full   <= 1'b0;
            hold_data   <= 12'h000;
            last_sample <= RESET_SAMPLE;
            channel     <= RESET_CH;
            cmd_word    <= 16'h0000;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;

            // A sample arriving on the frame-start edge is kept for the next frame, never bypassed.
            if (accept) begin
                hold_full <= 1'b1;
                hold_data <= sample_in;
            end else if (frame_start && hold_full) begin
                hold_full <= 1'b0;
            end
            if (frame_start && hold_full) begin
                last_sample <= hold_data;
            end

            case (state)
                IDLE: begin
                    if (!sync1) begin
                        sdo1  <= frame_word[15];
                        tx_sr <= frame_word[14:0];
                        rx_sr <= {14'd0, sdi1};
                        cnt   <= 5'd1;
                        state <= SHIFT;
                    end else begin
                        sdo1 <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (sync1) begin
                        frame_abort <= 1'b1;
                        sdo1        <= 1'b0;
                        cnt         <= 5'd0;
                        state       <= IDLE;
                    end else begin
                        sdo1  <= tx_sr[14];
                        tx_sr <= {tx_sr[13:0], 1'b0};
                        rx_sr <= rx_word[14:0];
                        cnt   <= cnt + 5'd1;
                        if (cnt == 5'd15) begin
                            cmd_word   <= rx_word;
                            frame_done <= 1'b1;
                            if (rx_word[15]) begin
                                channel <= rx_word[12:10];
                            end
                            state <= WAIT_HI;
                        end
                    end
                end
                WAIT_HI: begin
                    sdo1 <= 1'b0;
                    if (sync1) begin
                        cnt   <= 5'd0;
                        state <= IDLE;
                    end
                end
                default: begin
                    sdo1  <= 1'b0;
                    cnt   <= 5'd0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: frames driven and sampled on the falling
// edge of sclk, expected words computed by hand from the frame format.
module tb_adc_spi_responder;

    logic        sclk;
    logic        rst_n;
    logic        sync1;
    logic        sdi1;
    logic        sdo1;
    logic [11:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic [2:0]  channel;
    logic [15:0] cmd_word;
    logic        frame_done;
    logic        frame_abort;

    int total = 0;
    int bad   = 0;

    adc_spi_responder dut (
        .sclk         (sclk),
        .rst_n        (rst_n),
        .sync1        (sync1),
        .sdi1         (sdi1),
        .sdo1         (sdo1),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .channel      (channel),
        .cmd_word     (cmd_word),
        .frame_done   (frame_done),
        .frame_abort  (frame_abort)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic run_frame(input logic [15:0] cmd, input logic ld, input logic [11:0] sval,
                             output logic [15:0] word, output int ndone, output int nabort);
        word   = 16'h0000;
        ndone  = 0;
        nabort = 0;
        @(negedge sclk);
        sync1 = 1'b0;
        sdi1  = cmd[15];
        if (ld) begin
            sample_valid = 1'b1;
            sample_in    = sval;
        end
        for (int i = 0; i < 16; i++) begin
            @(posedge sclk);
            @(negedge sclk);
            sample_valid = 1'b0;
            word[15-i] = sdo1;
            if (frame_done) ndone++;
            if (frame_abort) nabort++;
            if (i < 15) sdi1 = cmd[14-i];
        end
        sync1 = 1'b1;
        sdi1  = 1'b0;
        @(posedge sclk);
        @(negedge sclk);
        if (frame_done) ndone++;
        if (frame_abort) nabort++;
    endtask

    task automatic load_sample(input logic [11:0] v);
        @(negedge sclk);
        sample_valid = 1'b1;
        sample_in    = v;
        @(posedge sclk);
        @(negedge sclk);
        sample_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge sclk);
        total++; if (sdo1 !== 1'b0) begin bad++; $display("FAIL reset_sdo got=%b want=0", sdo1); end
        total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", sample_ready); end
        total++; if (channel !== 3'd0) begin bad++; $display("FAIL reset_channel got=%0d want=0", channel); end
        total++; if (cmd_word !== 16'h0000) begin bad++; $display("FAIL reset_cmd got=%h want=0000", cmd_word); end
        total++; if ({frame_done, frame_abort} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b want=00", {frame_done, frame_abort}); end
        rst_n = 1'b1;
        @(negedge sclk);
    endtask

    task automatic test_basic;
        logic [15:0] w;
        int nd, na;
        run_frame(16'h0000, 1'b0, 12'h000, w, nd, na);
        total++; if (w !== 16'h8000) begin bad++; $display("FAIL basic_sdo got=%h want=8000", w); end
        total++; if (nd != 1) begin bad++; $display("FAIL basic_done got=%0d want=1", nd); end
        total++; if (na != 0) begin bad++; $display("FAIL basic_abort got=%0d want=0", na); end
        total++; if (channel !== 3'd0) begin bad++; $display("FAIL basic_channel got=%0d want=0", channel); end
        total++; if (sdo1 !== 1'b0) begin bad++; $display("FAIL basic_sdo_idle got=%b want=0", sdo1); end
    endtask

    task automatic test_write;
        logic [15:0] w;
        int nd, na;
        load_sample(12'hA5C);
        total++; if (sample_ready !== 1'b0) begin bad++; $display("FAIL write_ready_full got=%b want=0", sample_ready); end
        run_frame(16'h9400, 1'b0, 12'h000, w, nd, na);
        total++; if (w !== 16'h0A5C) begin bad++; $display("FAIL write_sdo1 got=%h want=0a5c", w); end
        total++; if (channel !== 3'd5) begin bad++; $display("FAIL write_channel got=%0d want=5", channel); end
        total++; if (cmd_word !== 16'h9400) begin bad++; $display("FAIL write_cmd got=%h want=9400", cmd_word); end
        total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL write_ready_empty got=%b want=1", sample_ready); end
        run_frame(16'h0000, 1'b0, 12'h000, w, nd, na);
        total++; if (w !== 16'hDA5C) begin bad++; $display("FAIL write_sdo2 got=%h want=da5c", w); end
        total++; if (channel !== 3'd5) begin bad++; $display("FAIL read_channel got=%0d want=5", channel); end
        total++; if (cmd_word !== 16'h0000) begin bad++; $display("FAIL read_cmd got=%h want=0000", cmd_word); end
    endtask

    task automatic test_abort;
        logic [15:0] w;
        int nd, na;
        @(negedge sclk);
        sync1 = 1'b0;
        sdi1  = 1'b1;
        repeat (7) begin
            @(posedge sclk);
            @(negedge sclk);
        end
        sync1 = 1'b1;
        @(posedge sclk);
        @(negedge sclk);
        total++; if (frame_abort !== 1'b1) begin bad++; $display("FAIL abort_pulse got=%b want=1", frame_abort); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", frame_done); end
        total++; if (sdo1 !== 1'b0) begin bad++; $display("FAIL abort_sdo got=%b want=0", sdo1); end
        total++; if (cmd_word !== 16'h0000) begin bad++; $display("FAIL abort_cmd got=%h want=0000", cmd_word); end
        total++; if (channel !== 3'd5) begin bad++; $display("FAIL abort_channel got=%0d want=5", channel); end
        sdi1 = 1'b0;
        @(posedge sclk);
        @(negedge sclk);
        total++; if (frame_abort !== 1'b0) begin bad++; $display("FAIL abort_one_cycle got=%b want=0", frame_abort); end
        run_frame(16'h0000, 1'b0, 12'h000, w, nd, na);
        total++; if (w !== 16'hDA5C) begin bad++; $display("FAIL abort_next_sdo got=%h want=da5c", w); end
        total++; if (nd != 1 || na != 0) begin bad++; $display("FAIL abort_next_pulses got=%0d/%0d want=1/0", nd, na); end
    endtask

    task automatic test_long_sync;
        logic [15:0] cmd;
        logic [15:0] w;
        int nd, zeros_bad;
        cmd = 16'h8000;
        w = 16'h0000;
        nd = 0;
        zeros_bad = 0;
        @(negedge sclk);
        sync1 = 1'b0;
        sdi1  = cmd[15];
        for (int i = 0; i < 20; i++) begin
            @(posedge sclk);
            @(negedge sclk);
            if (i < 16) w[15-i] = sdo1;
            else if (sdo1 !== 1'b0) zeros_bad++;
            if (frame_done) nd++;
            sdi1 = (i < 15) ? cmd[14-i] : 1'b0;
        end
        total++; if (w !== 16'hDA5C) begin bad++; $display("FAIL long_sdo got=%h want=da5c", w); end
        total++; if (nd != 1) begin bad++; $display("FAIL long_done got=%0d want=1", nd); end
        total++; if (zeros_bad != 0) begin bad++; $display("FAIL long_tail got=%0d nonzero want=0", zeros_bad); end
        total++; if (channel !== 3'd0) begin bad++; $display("FAIL long_channel got=%0d want=0", channel); end
        total++; if (cmd_word !== 16'h8000) begin bad++; $display("FAIL long_cmd got=%h want=8000", cmd_word); end
        sync1 = 1'b1;
        @(posedge sclk);
        @(negedge sclk);
    endtask

    task automatic test_simultaneous;
        logic [15:0] w;
        int nd, na;
        run_frame(16'h0000, 1'b1, 12'h123, w, nd, na);
        total++; if (w !== 16'h8A5C) begin bad++; $display("FAIL simul_stale_sdo got=%h want=8a5c", w); end
        total++; if (sample_ready !== 1'b0) begin bad++; $display("FAIL simul_stored got=%b want=0", sample_ready); end
        run_frame(16'h0000, 1'b0, 12'h000, w, nd, na);
        total++; if (w !== 16'h0123) begin bad++; $display("FAIL simul_next_sdo got=%h want=0123", w); end
        load_sample(12'h456);
        run_frame(16'h0000, 1'b1, 12'h789, w, nd, na);
        total++; if (w !== 16'h0456) begin bad++; $display("FAIL full_start_sdo got=%h want=0456", w); end
        total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL full_consumed got=%b want=1", sample_ready); end
        run_frame(16'h0000, 1'b0, 12'h000, w, nd, na);
        total++; if (w !== 16'h8456) begin bad++; $display("FAIL full_no_transfer got=%h want=8456", w); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] w;
        int nd, na, pulses;
        run_frame(16'h8C00, 1'b0, 12'h000, w, nd, na);
        total++; if (channel !== 3'd3) begin bad++; $display("FAIL rmid_pre_channel got=%0d want=3", channel); end
        load_sample(12'h3C3);
        @(negedge sclk);
        sync1 = 1'b0;
        sdi1  = 1'b1;
        repeat (9) begin
            @(posedge sclk);
            @(negedge sclk);
        end
        rst_n = 1'b0;
        sdi1  = 1'b0;
        #1;
        total++; if (sdo1 !== 1'b0) begin bad++; $display("FAIL rmid_sdo got=%b want=0", sdo1); end
        total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b want=1", sample_ready); end
        total++; if (channel !== 3'd0) begin bad++; $display("FAIL rmid_channel got=%0d want=0", channel); end
        total++; if (cmd_word !== 16'h0000) begin bad++; $display("FAIL rmid_cmd got=%h want=0000", cmd_word); end
        pulses = 0;
        repeat (3) begin
            @(posedge sclk);
            @(negedge sclk);
            if (frame_done || frame_abort || sdo1) pulses++;
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL rmid_quiet got=%0d want=0", pulses); end
        rst_n = 1'b1;
        w = 16'h0000;
        nd = 0;
        na = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge sclk);
            @(negedge sclk);
            w[15-i] = sdo1;
            if (frame_done) nd++;
            if (frame_abort) na++;
        end
        sync1 = 1'b1;
        @(posedge sclk);
        @(negedge sclk);
        total++; if (w !== 16'h8000) begin bad++; $display("FAIL rmid_next_sdo got=%h want=8000", w); end
        total++; if (nd != 1 || na != 0) begin bad++; $display("FAIL rmid_next_pulses got=%0d/%0d want=1/0", nd, na); end
    endtask

    initial begin
        rst_n        = 1'b0;
        sync1        = 1'b1;
        sdi1         = 1'b0;
        sample_in    = 12'h000;
        sample_valid = 1'b0;
        test_reset();
        test_basic();
        test_write();
        test_abort();
        test_long_sync();
        test_simultaneous();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_spi_responder.md
ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 Parameter RESET_CH, default 3'd0: channel value after reset.
REQ-002 Parameter RESET_SAMPLE, default 12'h000: transmitted sample value after reset if no sample is ever loaded.
REQ-003 SCLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 RST_N  input  1  reset; asynchronous, active-low.
REQ-005 SYNC1  input  1  frame sync from the SPI master, active-low.
REQ-006 SDI1  input  1  serial command bit from the master, MSB first.
REQ-007 SDO1  output  1  serial conversion data to the master, MSB first, registered.
REQ-008 SAMPLE_IN  input  12  parallel sample from the analog source model.
REQ-009 SAMPLE_VALID  input  1  SAMPLE_IN valid; a transfer occurs on an edge where SAMPLE_VALID=1 and SAMPLE_READY=1.
REQ-010 SAMPLE_READY  output  1  holding register empty.
REQ-011 CHANNEL  output  3  current channel address.
REQ-012 CMD_WORD  output  16  last complete 16-bit word received on SDI1.
REQ-013 FRAME_DONE  output  1  one-cycle pulse marking a completed 16-bit frame.
REQ-014 FRAME_ABORT  output  1  one-cycle pulse marking a frame ended early by SYNC1 high.

Function
REQ-015 The FSM SHALL have the states IDLE, SHIFT and WAIT_HI.
REQ-016 The frame word SHALL be {STALE, CHANNEL[2:0], SAMPLE[11:0]}, where STALE=1 if the holding register was empty at frame start.
REQ-017 IDLE, SYNC1 sampled 0: load the TX register with the frame word, drive bit15 onto SDO1, shift SDI1 into RX bit0, set bit count 1, go to SHIFT.
REQ-018 IDLE, SYNC1 sampled 1: hold SDO1=0.
REQ-019 SHIFT, SYNC1=0, count<16: drive the next TX bit on SDO1, shift in SDI1, increment the count.
REQ-020 In SHIFT, on the edge that captures the 16th SDI1 bit: load CMD_WORD from RX, pulse FRAME_DONE, go to WAIT_HI, drive SDO1=0 on the following edge.
REQ-021 Latency: SDO1 carries frame bit k in the cycle after the k-th low-sampled SYNC1 edge (k=15 down to 0).
REQ-022 SHIFT, SYNC1 sampled 1 before 16 bits: pulse FRAME_ABORT, go to IDLE, drive SDO1=0, discard RX; CMD_WORD and CHANNEL do not change.
REQ-023 WAIT_HI: stay until SYNC1 is sampled 1, then go to IDLE; a new frame needs at least one high-sampled cycle.
REQ-024 At frame completion, if RX[15]=1 (write), CHANNEL SHALL take RX[12:10] and the new value applies from the next frame.
REQ-025 At frame completion, if RX[15]=0, CHANNEL SHALL not change.
REQ-026 Holding register: SAMPLE_READY=1 when empty; an accepted SAMPLE_IN is stored and SAMPLE_READY goes low.
REQ-027 Frame start with the holding register full: send the stored sample with STALE=0, mark the register empty, and raise SAMPLE_READY next cycle.
REQ-028 Frame start with the holding register empty: resend the last transmitted sample (RESET_SAMPLE after reset) with STALE=1.
REQ-029 Simultaneous frame start and accepted SAMPLE_IN while empty: the current frame SHALL be STALE=1; the new sample SHALL be stored for the next frame (no bypass).
REQ-030 Simultaneous frame start and SAMPLE_VALID while full: SAMPLE_READY=0, so no transfer; the holding register SHALL be consumed.
REQ-031 FRAME_DONE and FRAME_ABORT SHALL never be high in the same cycle.

Reset
REQ-032 While RST_N=0, regardless of SCLK: state IDLE, SDO1=0, SAMPLE_READY=1, CHANNEL=RESET_CH, CMD_WORD=16'h0000, FRAME_DONE=0, FRAME_ABORT=0, last sample=RESET_SAMPLE, count=0.
REQ-033 Reset asserted mid-frame SHALL abandon the frame with no FRAME_DONE or FRAME_ABORT pulse; after release, SYNC1 already low SHALL start a new frame on the first edge.

Verification
REQ-034 Reset, no sample loaded, SYNC1 low for 16 cycles with SDI1=0: SDO1 serialises 16'h8000, FRAME_DONE pulses once, CHANNEL=0.
REQ-035 Load SAMPLE_IN=12'hA5C, send SDI1 word 16'h9400 (write, ch 5): frame 1 SDO1=16'h0A5C, CHANNEL=5 afterwards; frame 2 (no new sample) SDO1=16'hDA5C.
REQ-036 SYNC1 high after 7 bits: FRAME_ABORT pulses, CMD_WORD and CHANNEL unchanged, SDO1=0 next cycle, next frame is clean.
REQ-037 SYNC1 held low for 20 cycles: exactly one FRAME_DONE, SDO1=0 after bit0, no second frame until SYNC1 has gone high.
REQ-038 SAMPLE_VALID with 12'h123 on the frame-start edge while empty: frame STALE=1 with the old sample; next frame SDO1=16'h0123 (ch 0).
REQ-039 RST_N pulsed low at bit 9: all outputs at reset values, no pulses; frame after release sends 16'h8000.
